// File: rtl/topo_order_sched.sv
// Kahn-style topological sort sequencer driving an external indegree list and edge stream.
// Optional TOPO_CYCLE_CHECK_EN adds a sticky cycle_error output for graphs that did not fully drain.
module topo_order_sched #(
    parameter int MAX_NODES  = 1024,
    parameter int NODE_WIDTH = $clog2(MAX_NODES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NODE_WIDTH:0]   node_count,
    output logic [NODE_WIDTH-1:0] node_sel,
    output logic                  decrement_degree,
    input  logic [NODE_WIDTH-1:0] node_degree,
    output logic                  adj_req,
    output logic [NODE_WIDTH-1:0] adj_node,
    input  logic                  adj_valid,
    input  logic                  adj_none,
    input  logic                  adj_last,
    input  logic [NODE_WIDTH-1:0] adj_dst,
    output logic                  order_valid,
    output logic [NODE_WIDTH-1:0] order_node,
    output logic                  busy,
    output logic                  done
`ifdef TOPO_CYCLE_CHECK_EN
    ,
    output logic                  cycle_error
`endif
);

    // States: IDLE wait | SCAN read all degrees | SCAN_FLUSH judge last read | POP emit head
    //         FETCH consume edge beats | FLUSH judge last decrement | DONE sort finished
    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        SCAN_FLUSH,
        POP,
        FETCH,
        FLUSH,
        DONE
    } state_t;

    localparam logic [NODE_WIDTH:0]   ONE_W    = 1;
    localparam logic [NODE_WIDTH-1:0] ONE_N    = 1;
    localparam logic [NODE_WIDTH-1:0] PTR_LAST = NODE_WIDTH'(MAX_NODES - 1);

    state_t                state_q, state_d;
    logic [NODE_WIDTH:0]   count_q, count_d;
    logic [NODE_WIDTH:0]   emit_q, emit_d;
    logic [NODE_WIDTH-1:0] scan_idx_q, scan_idx_d;
    logic                  pend_q, pend_d;
    logic [NODE_WIDTH-1:0] pend_node_q, pend_node_d;

    logic [NODE_WIDTH-1:0] fifo_mem [MAX_NODES];
    logic [NODE_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [NODE_WIDTH:0]   fifo_cnt_q;
    logic                  fifo_empty;
    logic                  push, pop, launch;

    logic                  sel_dec, sel_req, sel_ov;
    logic [NODE_WIDTH-1:0] sel_node;
    logic [NODE_WIDTH:0]   scan_next;

    function automatic logic [NODE_WIDTH-1:0] ptr_inc(input logic [NODE_WIDTH-1:0] p);
        return (p == PTR_LAST) ? '0 : p + ONE_N;
    endfunction

    assign fifo_empty = (fifo_cnt_q == '0);
    // A read or decrement issued last cycle returns its degree now; zero means ready.
    assign push       = pend_q && (node_degree == '0);
    assign scan_next  = {1'b0, scan_idx_q} + ONE_W;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        emit_d      = emit_q;
        scan_idx_d  = scan_idx_q;
        pend_d      = 1'b0;
        pend_node_d = pend_node_q;
        pop         = 1'b0;
        launch      = 1'b0;
        sel_dec     = 1'b0;
        sel_req     = 1'b0;
        sel_ov      = 1'b0;
        sel_node    = '0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    launch     = 1'b1;
                    count_d    = node_count;
                    emit_d     = '0;
                    scan_idx_d = '0;
                    state_d    = (node_count == '0) ? SCAN_FLUSH : SCAN;
                end
            end
            SCAN: begin
                sel_node    = scan_idx_q;
                pend_d      = 1'b1;
                pend_node_d = scan_idx_q;
                scan_idx_d  = scan_next[NODE_WIDTH-1:0];
                if (scan_next == count_q) begin
                    state_d = SCAN_FLUSH;
                end
            end
            SCAN_FLUSH: begin
                state_d = POP;
            end
            POP: begin
                if (fifo_empty || (emit_q >= count_q)) begin
                    state_d = DONE;
                end else begin
                    pop     = 1'b1;
                    sel_ov  = 1'b1;
                    sel_req = 1'b1;
                    emit_d  = emit_q + ONE_W;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (adj_valid) begin
                    if (!adj_none) begin
                        sel_node    = adj_dst;
                        sel_dec     = 1'b1;
                        pend_d      = 1'b1;
                        pend_node_d = adj_dst;
                    end
                    if (adj_last || adj_none) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                state_d = POP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            emit_q      <= '0;
            scan_idx_q  <= '0;
            pend_q      <= 1'b0;
            pend_node_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            emit_q      <= emit_d;
            scan_idx_q  <= scan_idx_d;
            pend_q      <= pend_d;
            pend_node_q <= pend_node_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || launch) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + ONE_W;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - ONE_W;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            fifo_mem[wr_ptr_q] <= pend_node_q;
        end
    end

    // Outputs are masked by reset so nothing leaks while the state register is still settling.
    assign node_sel         = reset ? '0 : sel_node;
    assign decrement_degree = sel_dec && !reset;
    assign adj_req          = sel_req && !reset;
    assign order_valid      = sel_ov && !reset;
    assign adj_node         = (sel_req && !reset) ? fifo_mem[rd_ptr_q] : '0;
    assign order_node       = (sel_ov && !reset) ? fifo_mem[rd_ptr_q] : '0;
    assign busy             = !reset && (state_q != IDLE) && (state_q != DONE);
    assign done             = !reset && (state_q == DONE);

`ifdef TOPO_CYCLE_CHECK_EN
    logic cyc_err_q;

    always_ff @(posedge clk) begin
        if (reset || launch) begin
            cyc_err_q <= 1'b0;
        end else if ((state_q == POP) && (state_d == DONE)) begin
            cyc_err_q <= (emit_q < count_q);
        end
    end

    assign cycle_error = cyc_err_q && !reset;
`endif

endmodule

// File: tb/tb_topo_order_sched.sv
// Randomized bench for topo_order_sched: models the indegree list and edge source, and
// scoreboards the emitted order against a queue-based Kahn reference.
module tb_topo_order_sched;
    localparam int MAXN = 16;
    localparam int NW   = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [NW:0]   node_count = '0;
    logic [NW-1:0] node_sel, adj_node, order_node;
    logic [NW-1:0] node_degree = '0;
    logic [NW-1:0] adj_dst = '0;
    logic          adj_valid = 1'b0, adj_none = 1'b0, adj_last = 1'b0;
    logic          decrement_degree, adj_req, order_valid, busy, done;
`ifdef TOPO_CYCLE_CHECK_EN
    logic          cycle_error;
`endif

    always #5 clk = ~clk;

    topo_order_sched #(.MAX_NODES(MAXN)) dut (
        .clk(clk), .reset(reset), .start(start), .node_count(node_count),
        .node_sel(node_sel), .decrement_degree(decrement_degree), .node_degree(node_degree),
        .adj_req(adj_req), .adj_node(adj_node),
        .adj_valid(adj_valid), .adj_none(adj_none), .adj_last(adj_last), .adj_dst(adj_dst),
        .order_valid(order_valid), .order_node(order_node), .busy(busy), .done(done)
`ifdef TOPO_CYCLE_CHECK_EN
        , .cycle_error(cycle_error)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];
    int exp_emitted;
    int deg_init[MAXN];
    int adj[MAXN][$];
    int deg_mem[MAXN];
    int dec_cnt = 0;
    logic prev_ov = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic clear_graph();
        for (int i = 0; i < MAXN; i++) begin
            deg_init[i] = 0;
            adj[i].delete();
        end
    endtask

    task automatic add_edge(input int u, input int v);
        adj[u].push_back(v);
        deg_init[v]++;
    endtask

    // Kahn's algorithm with a FIFO ready list, scanning nodes in index order.
    task automatic build_expected(input int n);
        int d[MAXN];
        int q[$];
        int u, v;
        exp_emitted = 0;
        for (int i = 0; i < MAXN; i++) d[i] = deg_init[i];
        for (int i = 0; i < n; i++) if (d[i] == 0) q.push_back(i);
        while (q.size() > 0) begin
            u = q.pop_front();
            exp_q.push_back(u);
            exp_emitted++;
            for (int k = 0; k < adj[u].size(); k++) begin
                v = adj[u][k];
                d[v]--;
                if (d[v] == 0) q.push_back(v);
            end
        end
    endtask

    // Indegree list: degree of the selected node (after any decrement) appears one cycle later.
    initial begin
        int nd_next;
        forever begin
            @(negedge clk); #2;
            if (decrement_degree) begin
                deg_mem[node_sel] = deg_mem[node_sel] - 1;
                dec_cnt++;
            end
            nd_next = deg_mem[node_sel];
            @(posedge clk); #1;
            node_degree = nd_next[NW-1:0];
        end
    end

    // Edge source: answers each adj_req with the node's out-edges, random gaps, garbage when idle.
    task automatic serve(input int u);
        int e[$];
        e = adj[u];
        if (e.size() == 0) begin
            @(negedge clk);
            adj_valid = 1'b1; adj_none = 1'b1;
            adj_last = 1'($urandom_range(0, 1)); adj_dst = NW'($urandom);
        end else begin
            for (int k = 0; k < e.size(); k++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    adj_valid = 1'b0; adj_none = 1'($urandom_range(0, 1));
                    adj_last = 1'($urandom_range(0, 1)); adj_dst = NW'($urandom);
                end
                @(negedge clk);
                adj_valid = 1'b1; adj_none = 1'b0;
                adj_last = (k == e.size() - 1); adj_dst = NW'(e[k]);
            end
        end
        @(negedge clk);
        adj_valid = 1'b0; adj_none = 1'b0; adj_last = 1'b0; adj_dst = NW'($urandom);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (adj_req && !reset) serve(int'(adj_node));
        end
    end

    // Scoreboard monitor.
    initial begin
        int e;
        forever begin
            @(negedge clk); #1;
            if (order_valid) begin
                check("pulse_width", int'(prev_ov), 0);
                check("adj_req_with_order", int'(adj_req), 1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL order_extra: got node %0d, expected no order pulse", order_node);
                end else begin
                    e = exp_q.pop_front();
                    check("order_node", int'(order_node), e);
                    check("adj_node", int'(adj_node), e);
                end
            end else if (adj_req) begin
                n_checks++;
                $display("FAIL adj_req_alone: got adj_req=1 node %0d, expected 0", adj_node);
            end
            prev_ov = order_valid;
        end
    end

    task automatic check_quiet(input string tag);
        check({tag, "_order_valid"}, int'(order_valid), 0);
        check({tag, "_adj_req"}, int'(adj_req), 0);
        check({tag, "_decrement"}, int'(decrement_degree), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_node_sel"}, int'(node_sel), 0);
        check({tag, "_adj_node"}, int'(adj_node), 0);
        check({tag, "_order_node"}, int'(order_node), 0);
`ifdef TOPO_CYCLE_CHECK_EN
        check({tag, "_cycle_error"}, int'(cycle_error), 0);
`endif
    endtask

    task automatic wait_done(input string tag);
        int cyc = 0;
        while (done !== 1'b1 && cyc < 4000) begin
            @(negedge clk); #1;
            cyc++;
        end
        if (done !== 1'b1) begin
            n_checks++;
            $display("FAIL %s_timeout: done=%0b after %0d cycles, expected 1", tag, done, cyc);
        end
    endtask

    task automatic run_graph(input int n, input string tag, input bit restart_mid_scan);
        for (int i = 0; i < MAXN; i++) deg_mem[i] = deg_init[i];
        exp_q.delete();
        build_expected(n);
        dec_cnt = 0;
        @(negedge clk);
        start = 1'b1; node_count = (NW+1)'(n);
        @(negedge clk);
        start = 1'b0; node_count = (NW+1)'($urandom);
        if (restart_mid_scan && n > 0) begin
            start = 1'b1; node_count = (NW+1)'(1);
        end
        #1;
        check({tag, "_busy_after_start"}, int'(busy), 1);
        check({tag, "_done_cleared"}, int'(done), 0);
        if (restart_mid_scan) begin
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(tag);
        check({tag, "_done"}, int'(done), 1);
        check({tag, "_busy_at_done"}, int'(busy), 0);
        check({tag, "_orders_missing"}, exp_q.size(), 0);
`ifdef TOPO_CYCLE_CHECK_EN
        check({tag, "_cycle_error"}, int'(cycle_error), (exp_emitted < n) ? 1 : 0);
`endif
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    initial begin
        int n, cyc, k, v;
        int rank[MAXN];
        bit cyclic;

        repeat (3) @(negedge clk);
        #1 check_quiet("rst_hold");
        @(negedge clk);
        reset = 1'b0;
        #1 check_quiet("rst_after");

        clear_graph(); add_edge(0, 1); add_edge(1, 2);
        run_graph(3, "chain", 1'b0);

        clear_graph(); add_edge(0, 1); add_edge(0, 2); add_edge(1, 3); add_edge(2, 3);
        run_graph(4, "diamond", 1'b0);

        clear_graph();
        run_graph(4, "isolated", 1'b0);
        check("isolated_no_decrements", dec_cnt, 0);

        clear_graph(); add_edge(0, 1); add_edge(1, 2); add_edge(2, 0);
        run_graph(4, "cycle", 1'b0);

        // Reset during the first FETCH of the diamond, then a clean rerun.
        clear_graph(); add_edge(0, 1); add_edge(0, 2); add_edge(1, 3); add_edge(2, 3);
        for (int i = 0; i < MAXN; i++) deg_mem[i] = deg_init[i];
        exp_q.delete();
        build_expected(4);
        @(negedge clk);
        start = 1'b1; node_count = (NW+1)'(4);
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        #1;
        while (adj_req !== 1'b1 && cyc < 200) begin
            @(negedge clk); #1;
            cyc++;
        end
        check("rstfetch_adj_req_seen", int'(adj_req), 1);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        #1 check_quiet("rstfetch_hold");
        @(negedge clk);
        reset = 1'b0;
        #1 check_quiet("rstfetch_after");
        repeat (20) @(negedge clk);
        run_graph(4, "diamond_rerun", 1'b0);

        // Start during SCAN must be ignored.
        clear_graph();
        for (int u = 0; u < 9; u++) add_edge(u, u + 1);
        add_edge(0, 5); add_edge(2, 9);
        run_graph(10, "scan_restart", 1'b1);

        // node_count = 0: SCAN_FLUSH, POP, then DONE, no order pulse.
        clear_graph();
        exp_q.delete();
        @(negedge clk);
        start = 1'b1; node_count = '0;
        @(negedge clk);
        start = 1'b0;
        #1 check("zero_c1_done", int'(done), 0);
        check("zero_c1_busy", int'(busy), 1);
        @(negedge clk); #1;
        check("zero_c2_done", int'(done), 0);
        @(negedge clk); #1;
        check("zero_c3_done", int'(done), 1);
        check("zero_c3_busy", int'(busy), 0);
`ifdef TOPO_CYCLE_CHECK_EN
        check("zero_cycle_error", int'(cycle_error), 0);
`endif

        for (int t = 0; t < 25; t++) begin
            clear_graph();
            n = $urandom_range(1, MAXN);
            cyclic = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < MAXN; i++) rank[i] = i;
            for (int i = n - 1; i > 0; i--) begin
                int j, tmp;
                j = $urandom_range(0, i);
                tmp = rank[i]; rank[i] = rank[j]; rank[j] = tmp;
            end
            for (int u = 0; u < n; u++) begin
                k = $urandom_range(0, 3);
                for (int j = 0; j < k; j++) begin
                    v = $urandom_range(0, n - 1);
                    if ((cyclic || rank[v] > rank[u]) && deg_init[v] < 15) add_edge(u, v);
                end
            end
            run_graph(n, "random", 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
